i_type_sequencer: RTL and testbench

I_TYPE_SEQUENCER -- requirements
Module: i_type_sequencer

---
 rtl/i_type_sequencer.sv | 87 ++++++++
 tb/tb_i_type_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/i_type_sequencer.sv
// RV32I OP-IMM sequencer: accepts one instruction word, presents registered operands to
// an external I-type execute unit, and writes the result back into a 32x32 register file.
module i_type_sequencer #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr_data,
  output logic [31:0]        ex_idata,
  output logic [31:0]        ex_rv1,
  output logic [31:0]        ex_imm,
  input  logic [31:0]        ex_result,
  input  logic [4:0]         dbg_addr,
  output logic [31:0]        dbg_data,
  output logic               retire,
  output logic               illegal,
  output logic [COUNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_e;

  state_e      state_q;
  logic [31:0] rf_q [32];
  logic        legal_d;
  logic [4:0]  rd_d;

  // Only OP-IMM; shift-immediates additionally constrain funct7.
  always_comb begin
    legal_d = 1'b0;
    if (instr_data[6:0] == 7'b0010011) begin
      unique case (instr_data[14:12])
        3'b001:  legal_d = (instr_data[31:25] == 7'b0000000);
        3'b101:  legal_d = (instr_data[31:25] == 7'b0000000) ||
                           (instr_data[31:25] == 7'b0100000);
        default: legal_d = 1'b1;
      endcase
    end
  end

  assign rd_d        = ex_idata[11:7];
  assign instr_ready = (state_q == IDLE);
  assign dbg_data    = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ex_idata     <= '0;
      ex_rv1       <= '0;
      ex_imm       <= '0;
      retire       <= 1'b0;
      illegal      <= 1'b0;
      retire_count <= '0;
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      retire  <= 1'b0;
      illegal <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            if (legal_d) begin
              // rf_q[0] is never written, so rs1==x0 reads zero without a special case.
              ex_idata <= instr_data;
              ex_rv1   <= rf_q[instr_data[19:15]];
              ex_imm   <= {{20{instr_data[31]}}, instr_data[31:20]};
              state_q  <= EXEC;
            end else begin
              illegal <= 1'b1;
              state_q <= ERR;
            end
          end
        end
        EXEC: begin
          if (rd_d != 5'd0) rf_q[rd_d] <= ex_result;
          retire       <= 1'b1;
          retire_count <= retire_count + COUNT_W'(1);
          state_q      <= WB;
        end
        WB:      state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i_type_sequencer.sv
// Directed self-checking bench for i_type_sequencer; a second instance with a 2-bit
// retire counter exercises counter wrap-around alongside the default-width instance.
module tb_i_type_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, instr_ready_s;
  logic [31:0] instr_data = '0;
  logic [31:0] ex_idata, ex_rv1, ex_imm;
  logic [31:0] ex_idata_s, ex_rv1_s, ex_imm_s;
  logic [31:0] ex_result = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data, dbg_data_s;
  logic        retire, illegal, retire_s, illegal_s;
  logic [31:0] retire_count;
  logic [1:0]  retire_count_s;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  i_type_sequencer #(.COUNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .ex_idata(ex_idata), .ex_rv1(ex_rv1), .ex_imm(ex_imm),
    .ex_result(ex_result), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .retire(retire), .illegal(illegal), .retire_count(retire_count)
  );

  i_type_sequencer #(.COUNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready_s),
    .instr_data(instr_data), .ex_idata(ex_idata_s), .ex_rv1(ex_rv1_s), .ex_imm(ex_imm_s),
    .ex_result(ex_result), .dbg_addr(dbg_addr), .dbg_data(dbg_data_s),
    .retire(retire_s), .illegal(illegal_s), .retire_count(retire_count_s)
  );

  typedef struct {
    logic [31:0] w;
    logic [31:0] res;
    logic [31:0] rv1;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] rdv;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b1;
    instr_data = 32'h00500093;
    tick();
    tick();
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b expected 1", instr_ready); end
    n_checks++; if (ex_idata !== 32'h0) begin n_fail++; $display("FAIL reset ex_idata: got %h expected 00000000", ex_idata); end
    n_checks++; if (retire !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset pulses: got retire=%b illegal=%b expected 0 0", retire, illegal); end
    n_checks++; if (retire_count !== 32'd0) begin n_fail++; $display("FAIL reset count: got %0d expected 0", retire_count); end
    rst = 1'b0;
    instr_valid = 1'b0;
    tick();
    n_checks++; if (instr_ready !== 1'b1 || ex_imm !== 32'h0) begin n_fail++; $display("FAIL reset release: got ready=%b imm=%h expected 1 00000000", instr_ready, ex_imm); end
    exp_count = 0;
  endtask

  task automatic test_legal();
    vec_t lt[5];
    lt[0] = '{32'h00500093, 32'd5,      32'd5 - 32'd5, 32'h00000005, 5'd1, 32'd5};
    lt[1] = '{32'hFFF08113, 32'd4,      32'd5,         32'hFFFFFFFF, 5'd2, 32'd4};
    lt[2] = '{32'h00700013, 32'd7,      32'd0,         32'h00000007, 5'd0, 32'd0};
    lt[3] = '{32'h40415193, 32'h1234,   32'd4,         32'h00000404, 5'd3, 32'h1234};
    lt[4] = '{32'h00111213, 32'd8,      32'd4,         32'h00000001, 5'd4, 32'd8};
    for (int i = 0; i < 5; i++) begin
      instr_data  = lt[i].w;
      ex_result   = lt[i].res;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      n_checks++; if (ex_idata !== lt[i].w) begin n_fail++; $display("FAIL legal[%0d] ex_idata: got %h expected %h", i, ex_idata, lt[i].w); end
      n_checks++; if (ex_rv1 !== lt[i].rv1) begin n_fail++; $display("FAIL legal[%0d] ex_rv1: got %h expected %h", i, ex_rv1, lt[i].rv1); end
      n_checks++; if (ex_imm !== lt[i].imm) begin n_fail++; $display("FAIL legal[%0d] ex_imm: got %h expected %h", i, ex_imm, lt[i].imm); end
      n_checks++; if (instr_ready !== 1'b0 || retire !== 1'b0) begin n_fail++; $display("FAIL legal[%0d] exec ctl: got ready=%b retire=%b expected 0 0", i, instr_ready, retire); end
      tick();
      exp_count++;
      n_checks++; if (retire !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL legal[%0d] wb pulse: got retire=%b illegal=%b expected 1 0", i, retire, illegal); end
      n_checks++; if (retire_count !== 32'(exp_count)) begin n_fail++; $display("FAIL legal[%0d] count: got %0d expected %0d", i, retire_count, exp_count); end
      n_checks++; if (retire_count_s !== 2'(exp_count)) begin n_fail++; $display("FAIL legal[%0d] small count: got %0d expected %0d", i, retire_count_s, exp_count % 4); end
      tick();
      dbg_addr = lt[i].rd;
      #1;
      n_checks++; if (retire !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL legal[%0d] idle: got retire=%b ready=%b expected 0 1", i, retire, instr_ready); end
      n_checks++; if (dbg_data !== lt[i].rdv) begin n_fail++; $display("FAIL legal[%0d] rd x%0d: got %h expected %h", i, lt[i].rd, dbg_data, lt[i].rdv); end
      n_checks++; if (ex_idata !== lt[i].w) begin n_fail++; $display("FAIL legal[%0d] hold ex_idata: got %h expected %h", i, ex_idata, lt[i].w); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] il[4];
    il[0] = 32'h00000033;
    il[1] = 32'h20415193;
    il[2] = 32'h02111093;
    il[3] = 32'h0050A083;
    ex_result = 32'hDEADBEEF;
    dbg_addr  = 5'd3;
    for (int i = 0; i < 4; i++) begin
      instr_data  = il[i];
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      n_checks++; if (illegal !== 1'b1 || retire !== 1'b0 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL illegal[%0d] err: got illegal=%b retire=%b ready=%b expected 1 0 0", i, illegal, retire, instr_ready); end
      n_checks++; if (ex_idata !== 32'h00111213) begin n_fail++; $display("FAIL illegal[%0d] ex_idata: got %h expected 00111213", i, ex_idata); end
      tick();
      n_checks++; if (illegal !== 1'b0 || retire !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL illegal[%0d] idle: got illegal=%b retire=%b ready=%b expected 0 0 1", i, illegal, retire, instr_ready); end
      n_checks++; if (retire_count !== 32'(exp_count) || dbg_data !== 32'h1234) begin n_fail++; $display("FAIL illegal[%0d] state: got count=%0d x3=%h expected %0d 00001234", i, retire_count, dbg_data, exp_count); end
    end
  endtask

  task automatic test_back_to_back();
    instr_data  = 32'h00120213;
    ex_result   = 32'd9;
    instr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (instr_ready !== (i % 3 == 0)) begin n_fail++; $display("FAIL b2b ready cycle %0d: got %b expected %b", i, instr_ready, (i % 3 == 0)); end
      if (i == 1) begin
        n_checks++; if (ex_rv1 !== 32'd8) begin n_fail++; $display("FAIL b2b first rv1: got %h expected 00000008", ex_rv1); end
      end
      if (i == 4) begin
        n_checks++; if (ex_rv1 !== 32'd9) begin n_fail++; $display("FAIL b2b dependent rv1: got %h expected 00000009", ex_rv1); end
      end
      tick();
    end
    instr_valid = 1'b0;
    exp_count += 3;
    dbg_addr = 5'd4;
    #1;
    n_checks++; if (retire_count !== 32'(exp_count)) begin n_fail++; $display("FAIL b2b count: got %0d expected %0d", retire_count, exp_count); end
    n_checks++; if (retire_count_s !== 2'(exp_count)) begin n_fail++; $display("FAIL b2b wrapped count: got %0d expected %0d", retire_count_s, exp_count % 4); end
    n_checks++; if (dbg_data !== 32'd9) begin n_fail++; $display("FAIL b2b x4: got %h expected 00000009", dbg_data); end
  endtask

  task automatic test_reset_mid_exec();
    instr_data  = 32'h06300293;
    ex_result   = 32'd99;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_checks++; if (ex_imm !== 32'h63 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL abort exec: got imm=%h ready=%b expected 00000063 0", ex_imm, instr_ready); end
    rst = 1'b1;
    tick();
    n_checks++; if (retire !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL abort pulses: got retire=%b illegal=%b expected 0 0", retire, illegal); end
    rst = 1'b0;
    dbg_addr = 5'd5;
    tick();
    exp_count = 0;
    n_checks++; if (instr_ready !== 1'b1 || retire !== 1'b0) begin n_fail++; $display("FAIL abort idle: got ready=%b retire=%b expected 1 0", instr_ready, retire); end
    n_checks++; if (retire_count !== 32'd0) begin n_fail++; $display("FAIL abort count: got %0d expected 0", retire_count); end
    n_checks++; if (dbg_data !== 32'd0) begin n_fail++; $display("FAIL abort x5: got %h expected 00000000", dbg_data); end
    dbg_addr = 5'd4;
    #1;
    n_checks++; if (dbg_data !== 32'd0) begin n_fail++; $display("FAIL abort rf clear x4: got %h expected 00000000", dbg_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_legal();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
